// File: rtl/pwm_bank.sv
// rtl/pwm_bank.sv - bank of PWM channels with double-buffered duty frames and commit timeout
module pwm_bank #(
    parameter int CHANNELS     = 8,
    parameter int WIDTH        = 16,
    parameter int STALE_CYCLES = 8191
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [WIDTH-1:0]    data,
    input  logic [2:0]          address,
    input  logic                writeStrobe,
    output logic [CHANNELS-1:0] pwm,
    output logic                periodStart,
    output logic                stale
);

    localparam int SW = $clog2(STALE_CYCLES + 1);
    localparam logic [SW-1:0]    STALE_MAX = SW'(STALE_CYCLES);
    localparam logic [WIDTH-1:0] CNT_MAX   = '1;

    logic [WIDTH-1:0]    counter_q, counter_d;
    logic [WIDTH-1:0]    shadow_q [CHANNELS];
    logic [WIDTH-1:0]    shadow_d [CHANNELS];
    logic [WIDTH-1:0]    active_q [CHANNELS];
    logic [WIDTH-1:0]    active_d [CHANNELS];
    logic                commit_pending_q, commit_pending_d;
    logic [SW-1:0]       stale_cnt_q, stale_cnt_d;
    logic                stale_q, stale_d;
    logic                period_start_q, period_start_d;
    logic [CHANNELS-1:0] pwm_q, pwm_d;

    logic write_ok;
    logic commit_write;
    logic wrap;

    always_comb begin
        write_ok     = writeStrobe && ({29'b0, address} < 32'(CHANNELS));
        commit_write = write_ok && ({29'b0, address} == 32'(CHANNELS - 1));
        wrap         = (counter_q == CNT_MAX);

        counter_d = counter_q + WIDTH'(1);

        shadow_d = shadow_q;
        if (write_ok) begin
            shadow_d[address] = data;
        end

        // Frame swap uses the pre-edge shadow, so a commit on the wrap edge lands next period.
        active_d = active_q;
        if (wrap && commit_pending_q) begin
            active_d = shadow_q;
        end

        commit_pending_d = commit_pending_q;
        if (commit_write) begin
            commit_pending_d = 1'b1;
        end else if (wrap) begin
            commit_pending_d = 1'b0;
        end

        stale_cnt_d = stale_cnt_q;
        if (commit_write) begin
            stale_cnt_d = '0;
        end else if (stale_cnt_q != STALE_MAX) begin
            stale_cnt_d = stale_cnt_q + SW'(1);
        end
        stale_d = (stale_cnt_d == STALE_MAX);

        period_start_d = (counter_q == '0);

        // Gate with the next stale value so pwm and stale always agree in the same cycle.
        pwm_d = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            pwm_d[i] = (counter_q < active_q[i]) && !stale_d;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            counter_q        <= '0;
            shadow_q         <= '{default: '0};
            active_q         <= '{default: '0};
            commit_pending_q <= 1'b0;
            stale_cnt_q      <= '0;
            stale_q          <= 1'b0;
            period_start_q   <= 1'b0;
            pwm_q            <= '0;
        end else begin
            counter_q        <= counter_d;
            shadow_q         <= shadow_d;
            active_q         <= active_d;
            commit_pending_q <= commit_pending_d;
            stale_cnt_q      <= stale_cnt_d;
            stale_q          <= stale_d;
            period_start_q   <= period_start_d;
            pwm_q            <= pwm_d;
        end
    end

    assign pwm         = pwm_q;
    assign periodStart = period_start_q;
    assign stale       = stale_q;

endmodule

// File: tb/tb_pwm_bank.sv
// tb/tb_pwm_bank.sv - directed bench for pwm_bank with a per-cycle scoreboard
module tb_pwm_bank;

    localparam int CH  = 8;
    localparam int W   = 8;
    localparam int ST  = 2000;
    localparam int TOP = 255;
    localparam int PER = 256;

    logic         clock = 1'b0;
    logic         reset = 1'b1;
    logic [W-1:0] data = '0;
    logic [2:0]   address = '0;
    logic         writeStrobe = 1'b0;
    logic [CH-1:0] pwm;
    logic         periodStart;
    logic         stale;

    int checks = 0;
    int errors = 0;

    logic [9:0] sb [$];
    logic [9:0] exp_out;

    int  m_cnt = 0;
    int  m_sc = 0;
    bit  m_pend = 0;
    int  m_sh [CH];
    int  m_act [CH];
    bit  m_wr, m_commit, m_ps, m_st;
    int  m_nsc;
    logic [CH-1:0] m_pwm;

    int hi_cnt [CH];
    int ps_cnt;

    pwm_bank #(.CHANNELS(CH), .WIDTH(W), .STALE_CYCLES(ST)) dut (
        .clock       (clock),
        .reset       (reset),
        .data        (data),
        .address     (address),
        .writeStrobe (writeStrobe),
        .pwm         (pwm),
        .periodStart (periodStart),
        .stale       (stale)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference model: expected outputs after each edge go into the scoreboard.
    initial forever begin
        @(posedge clock or posedge reset);
        if (reset) begin
            m_cnt = 0;
            m_sc = 0;
            m_pend = 0;
            for (int i = 0; i < CH; i++) begin
                m_sh[i] = 0;
                m_act[i] = 0;
            end
            sb.delete();
        end else begin
            m_wr     = writeStrobe && (int'(address) < CH);
            m_commit = m_wr && (int'(address) == CH - 1);
            m_nsc    = m_commit ? 0 : ((m_sc < ST) ? m_sc + 1 : ST);
            m_st     = (m_nsc == ST);
            for (int i = 0; i < CH; i++) begin
                m_pwm[i] = !m_st && (m_cnt < m_act[i]);
            end
            m_ps = (m_cnt == 0);
            if (m_cnt == TOP && m_pend) begin
                for (int i = 0; i < CH; i++) m_act[i] = m_sh[i];
            end
            if (m_commit) m_pend = 1;
            else if (m_cnt == TOP) m_pend = 0;
            if (m_wr) m_sh[address] = int'(data);
            m_cnt = (m_cnt + 1) % PER;
            m_sc  = m_nsc;
            sb.push_back({m_pwm, m_ps, m_st});
        end
    end

    initial forever begin
        @(negedge clock);
        if (reset) begin
            chk("reset_outputs", {22'b0, pwm, periodStart, stale}, 32'h0);
        end else if (sb.size() > 0) begin
            exp_out = sb.pop_front();
            chk("cycle_outputs", {22'b0, pwm, periodStart, stale}, {22'b0, exp_out});
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic wr(input int ch, input int val);
        address     = 3'(ch);
        data        = W'(val);
        writeStrobe = 1'b1;
        @(negedge clock);
        writeStrobe = 1'b0;
    endtask

    task automatic wait_cnt(input int v);
        int n = 0;
        while (m_cnt != v && n < 600) begin
            @(negedge clock);
            n++;
        end
        chk("wait_counter", m_cnt, v);
    endtask

    task automatic measure();
        int n = 0;
        for (int c = 0; c < CH; c++) hi_cnt[c] = 0;
        ps_cnt = 0;
        do begin
            @(negedge clock);
            n++;
        end while (!periodStart && n < 600);
        chk("period_start_seen", {31'b0, periodStart}, 32'h1);
        for (int k = 0; k < PER; k++) begin
            if (k > 0) @(negedge clock);
            for (int c = 0; c < CH; c++) hi_cnt[c] += int'(pwm[c]);
            ps_cnt += int'(periodStart);
        end
        chk("period_start_once", ps_cnt, 1);
    endtask

    initial begin
        repeat (3) @(negedge clock);
        #2 reset = 1'b0;
        @(negedge clock);
        chk("first_edge_period_start", {31'b0, periodStart}, 32'h1);

        // Full frame at half duty, committed mid-period
        wait_cnt(16);
        for (int c = 0; c < CH; c++) wr(c, 'h80);
        wait_cnt(TOP);
        chk("active_unchanged_before_wrap", {24'b0, pwm}, 32'h0);
        measure();
        for (int c = 0; c < CH; c++) chk("half_duty_high", hi_cnt[c], 128);

        // Duty extremes
        wr(0, 'h00);
        wr(1, 'hFF);
        wr(7, 'h80);
        measure();
        chk("duty_zero_high", hi_cnt[0], 0);
        chk("duty_max_high", hi_cnt[1], 255);
        chk("ch7_half_high", hi_cnt[7], 128);

        // Shadow write without commit must not reach active
        wr(3, 'h10);
        repeat (3) begin
            measure();
            chk("uncommitted_ch3", hi_cnt[3], 128);
        end

        // Commit on the wrap edge: old shadow now, new ch7 one period later
        wait_cnt(128);
        wr(7, 'h20);
        wait_cnt(TOP);
        wr(7, 'h40);
        measure();
        chk("wrap_commit_old_ch7", hi_cnt[7], 32);
        chk("wrap_commit_ch3", hi_cnt[3], 16);
        measure();
        chk("wrap_commit_new_ch7", hi_cnt[7], 64);

        // Staleness timeout and recovery
        wr(7, 'h40);
        repeat (ST - 1) @(negedge clock);
        chk("stale_before_limit", {31'b0, stale}, 32'h0);
        @(negedge clock);
        chk("stale_at_limit", {31'b0, stale}, 32'h1);
        chk("pwm_forced_low", {24'b0, pwm}, 32'h0);
        wr(7, 'h40);
        chk("stale_cleared", {31'b0, stale}, 32'h0);
        begin
            int n = 0;
            while (!pwm[7] && n < 300) begin
                @(negedge clock);
                n++;
            end
        end
        chk("pwm_resumed", {31'b0, pwm[7]}, 32'h1);

        // Reset with a pending frame
        wait_cnt(48);
        wr(0, 'h55);
        wr(7, 'h10);
        wait_cnt(64);
        #2 reset = 1'b1;
        #1;
        chk("reset_pwm", {24'b0, pwm}, 32'h0);
        chk("reset_period_start", {31'b0, periodStart}, 32'h0);
        chk("reset_stale", {31'b0, stale}, 32'h0);
        @(negedge clock);
        @(negedge clock);
        #2 reset = 1'b0;
        @(negedge clock);
        chk("restart_period_start", {31'b0, periodStart}, 32'h1);
        measure();
        for (int c = 0; c < CH; c++) chk("no_frame_after_reset", hi_cnt[c], 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pwm_bank.md
PWM_BANK -- requirements
Module: pwm_bank

Interface
REQ-001 Parameter CHANNELS, default 8: number of PWM outputs, one per address value.
REQ-002 Parameter WIDTH, default 16: bit width of the duty and period counter.
REQ-003 Parameter STALE_CYCLES, default 8191: number of clocks without a frame commit before outputs are forced low.
REQ-004 clock  input  1  system clock; the only clock.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 data  input  WIDTH  duty value for the addressed channel, already in the clock domain.
REQ-007 address  input  3  channel index, 0..CHANNELS-1.
REQ-008 writeStrobe  input  1  single-cycle pulse; data/address are valid only in that cycle.
REQ-009 pwm  output  CHANNELS  registered PWM outputs, bit i = channel i.
REQ-010 periodStart  output  1  one-cycle pulse in the cycle after the counter wraps to 0.
REQ-011 stale  output  1  high while outputs are forced low because commits have timed out.

Function
REQ-012 The block SHALL hold shadow[0..CHANNELS-1] and active[0..CHANNELS-1] registers, each WIDTH bits wide.
REQ-013 writeStrobe=1 SHALL write data into shadow[address] on that edge; active SHALL NOT change on a write.
REQ-014 A write with address==CHANNELS-1 SHALL set commitPending on the same edge (frame commit).
REQ-015 The period counter SHALL be a WIDTH-bit free-running counter, 0..2^WIDTH-1, that wraps to 0.
REQ-016 On the edge where counter==2^WIDTH-1 and the pre-edge commitPending==1:
  - all active[i] SHALL load the pre-edge shadow[i] values;
  - commitPending SHALL clear.
REQ-017 A commit write that lands on the same edge as REQ-016 SHALL:
  - win the commitPending update (it stays 1);
  - let active take the old shadow values;
  - apply the new frame at the following wrap.
REQ-018 pwm[i] SHALL be registered as (counter < active[i]) && !stale, one clock of latency from the counter value.
  - active[i]==0 gives constant low.
  - active[i]==2^WIDTH-1 gives low for exactly 1 clock per period.
REQ-019 periodStart SHALL be registered as (counter==0), i.e. high for exactly 1 clock every 2^WIDTH clocks.
REQ-020 The staleness counter SHALL saturate and behave as follows:
  - it clears on every commit write (REQ-014);
  - it otherwise increments, saturating at STALE_CYCLES;
  - stale SHALL be 1 while the counter equals STALE_CYCLES.
REQ-021 The stale flag SHALL clear on the edge of the next commit write; pwm resumes on the cycle after that edge, using the existing active values.
REQ-022 A write with address >= CHANNELS SHALL be ignored entirely: no shadow write, no commit, no stale clear.
REQ-023 Writes to channels 0..CHANNELS-2 alone SHALL NOT commit, clear stale or affect active.

Reset
REQ-024 While reset=1, the following SHALL be cleared asynchronously:
  - counter=0, all shadow=0, all active=0, commitPending=0, periodStart=0;
  - pwm=0, stale counter=0, stale=0.
REQ-025 Reset asserted mid-period or mid-frame SHALL discard any pending partial frame; after release the counter restarts at 0.
REQ-026 The first rising edge after reset deassertion SHALL behave as a normal operating edge.

Verification
REQ-027 Write ch0..ch7 with 0x8000, ch7 last, at counter=0x1000 -> active unchanged until the wrap; then every pwm bit is high for 32768 clocks and low for 32768 clocks per period.
REQ-028 Write ch3=0x0010 only (no ch7 write) -> pwm[3] duty does not change across 3 periods.
REQ-029 Commit write of ch7 on the edge where counter==0xFFFF -> active loads the old shadow; the new ch7 value appears one period later.
REQ-030 Duty 0x0000 and 0xFFFF on ch0/ch1 -> pwm[0] is never high; pwm[1] is low for exactly 1 clock per period.
REQ-031 Commit, then no writes for 8191 clocks -> stale=1 and pwm=0; a ch7 write -> stale=0 and pwm resumes on the next cycle.
REQ-032 Assert reset at counter=0x4000 with commitPending=1 -> all outputs read 0 immediately; after release no frame is applied and the counter counts from 0.
